// File: rtl/arch_state_snapshot_if.sv
`default_nettype none
// ============================================================================
//  Module   : arch_state_snapshot_if
//  Purpose  : Groups every signal of the architectural-state snapshot block
//             except clock and reset: the request handshake, the core halt
//             handshake, the PC/privilege/CLINT inputs, the CSR and
//             register-file read ports, and the record output stream.
//  Modports : master - the snapshot engine (drives halt_req, read addresses
//                      and the record stream)
//             slave  - the surrounding tile (core, CSR file, register files,
//                      record consumer)
//  Revision : 1.0 - initial release
// ============================================================================
interface arch_state_snapshot_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            halt_req;
    logic            halt_ack;
    logic [XLEN-1:0] pc_in;
    logic [1:0]      prv_in;
    logic [XLEN-1:0] time_in;
    logic [XLEN-1:0] timecmp_in;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_data;
    logic            rf_sel;
    logic [4:0]      rf_addr;
    logic [XLEN-1:0] rf_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [6:0]      out_index;
    logic            out_last;
    logic            done;
    logic            timeout_err;

    modport master (
        input  req_valid, halt_ack, pc_in, prv_in, time_in, timecmp_in,
               csr_data, rf_data, out_ready,
        output req_ready, halt_req, csr_addr, rf_sel, rf_addr,
               out_valid, out_data, out_index, out_last, done, timeout_err
    );

    modport slave (
        output req_valid, halt_ack, pc_in, prv_in, time_in, timecmp_in,
               csr_data, rf_data, out_ready,
        input  req_ready, halt_req, csr_addr, rf_sel, rf_addr,
               out_valid, out_data, out_index, out_last, done, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/arch_state_snapshot.sv
`default_nettype none
// ============================================================================
//  Module   : arch_state_snapshot
//  Purpose  : Halts the core, reads its architectural state through
//             1-cycle-latency read ports and streams it as XLEN-bit records
//             in loadarch image order, then resumes the core.
//  Ports    : clock - single clock
//             reset - asynchronous, active-high
//             bus   - arch_state_snapshot_if.master (request, halt
//                     handshake, CSR/RF read ports, record stream)
//  Records  : 0 pc, 1 prv, 2..20 CSRs, 21 mtime, 22 mtimecmp,
//             23..54 x0..x31, 55..86 f0..f31 (only when FPR_EN=1)
//  Revision : 1.0 - initial release
// ============================================================================
module arch_state_snapshot #(
    parameter int XLEN         = 64,
    parameter bit FPR_EN       = 1'b1,
    parameter int HALT_TIMEOUT = 1024
) (
    input  wire logic           clock,
    input  wire logic           reset,
    arch_state_snapshot_if.master bus
);
    localparam int              CNT_W    = $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [6:0]      LAST_IDX = FPR_EN ? 7'd86 : 7'd54;
    localparam logic [6:0]      IDX_PRV  = 7'd1;
    localparam logic [6:0]      IDX_CSR1 = 7'd20;
    localparam logic [6:0]      IDX_TIME = 7'd21;
    localparam logic [6:0]      IDX_TCMP = 7'd22;
    localparam logic [6:0]      IDX_X0   = 7'd23;
    localparam logic [6:0]      IDX_F0   = 7'd55;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HALT    = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_SEND    = 3'd4,
        S_RESUME  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [1:0]       prv_q, prv_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [6:0]       oidx_q, oidx_d;
    logic             last_q, last_d;
    logic             terr_q, terr_d;
    logic [11:0]      csr_addr_w;
    logic             rf_sel_w;
    logic [4:0]       rf_addr_w;

    // CSR address for records 2..20.
    function automatic logic [11:0] csr_of(input logic [6:0] idx);
        logic [11:0] a;
        a = 12'h000;
        case (idx)
            7'd2:  a = 12'h003;
            7'd3:  a = 12'h105;
            7'd4:  a = 12'h140;
            7'd5:  a = 12'h141;
            7'd6:  a = 12'h142;
            7'd7:  a = 12'h143;
            7'd8:  a = 12'h180;
            7'd9:  a = 12'h300;
            7'd10: a = 12'h302;
            7'd11: a = 12'h303;
            7'd12: a = 12'h304;
            7'd13: a = 12'h305;
            7'd14: a = 12'h340;
            7'd15: a = 12'h341;
            7'd16: a = 12'h342;
            7'd17: a = 12'h343;
            7'd18: a = 12'h344;
            7'd19: a = 12'hB00;
            7'd20: a = 12'hB02;
            default: a = 12'h000;
        endcase
        return a;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pc_q    <= '0;
            prv_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            prv_q   <= prv_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        prv_d      = prv_q;
        data_d     = data_q;
        oidx_d     = oidx_q;
        last_d     = last_q;
        terr_d     = 1'b0;
        csr_addr_w = 12'h000;
        rf_sel_w   = 1'b0;
        rf_addr_w  = 5'd0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.req_valid) begin
                    state_d = S_HALT;
                    idx_d   = 7'd0;
                end
            end
            S_HALT: begin
                if (bus.halt_ack) begin
                    pc_d    = bus.pc_in;
                    prv_d   = bus.prv_in;
                    state_d = S_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
                if (idx_q > IDX_PRV && idx_q <= IDX_CSR1) begin
                    csr_addr_w = csr_of(idx_q);
                end else if (idx_q > IDX_X0) begin
                    // Both files start 23 / 55 records in; 55-23 = 32, so the
                    // register number is (idx - 23) mod 32 = (idx + 9) mod 32.
                    rf_sel_w  = (idx_q >= IDX_F0);
                    rf_addr_w = idx_q[4:0] + 5'd9;
                end
            end
            S_CAPTURE: begin
                state_d = S_SEND;
                oidx_d  = idx_q;
                last_d  = (idx_q == LAST_IDX);
                if (idx_q == 7'd0)
                    data_d = pc_q;
                else if (idx_q == IDX_PRV)
                    data_d = {{(XLEN-2){1'b0}}, prv_q};
                else if (idx_q <= IDX_CSR1)
                    data_d = bus.csr_data;
                else if (idx_q == IDX_TIME)
                    data_d = bus.time_in;
                else if (idx_q == IDX_TCMP)
                    data_d = bus.timecmp_in;
                else if (idx_q == IDX_X0)
                    data_d = '0;
                else
                    data_d = bus.rf_data;
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RESUME;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_RESUME: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode directly from the state register so reset
    // clears them without waiting for a clock edge.
    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.halt_req    = (state_q == S_HALT) || (state_q == S_ISSUE) ||
                             (state_q == S_CAPTURE) || (state_q == S_SEND);
    assign bus.out_valid   = (state_q == S_SEND);
    assign bus.done        = (state_q == S_RESUME);
    assign bus.timeout_err = terr_q;
    assign bus.out_data    = data_q;
    assign bus.out_index   = oidx_q;
    assign bus.out_last    = last_q;
    assign bus.csr_addr    = csr_addr_w;
    assign bus.rf_sel      = rf_sel_w;
    assign bus.rf_addr     = rf_addr_w;
endmodule
`default_nettype wire

// File: tb/tb_arch_state_snapshot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arch_state_snapshot
//  Purpose  : Directed self-checking bench for arch_state_snapshot. Instance
//             A has FPR_EN=1, instance B has FPR_EN=0; both use a 16-cycle
//             halt timeout. A record monitor compares every accepted record
//             against a model of the record table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arch_state_snapshot;
    localparam logic [63:0] TIME_V = 64'h1111_2222_3333_4444;
    localparam logic [63:0] TCMP_V = 64'h5555_6666_7777_8888;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arch_state_snapshot_if #(.XLEN(64)) ifa ();
    arch_state_snapshot_if #(.XLEN(64)) ifb ();

    arch_state_snapshot #(.XLEN(64), .FPR_EN(1'b1), .HALT_TIMEOUT(16)) u_dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (ifa.master)
    );
    arch_state_snapshot #(.XLEN(64), .FPR_EN(1'b0), .HALT_TIMEOUT(16)) u_dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (ifb.master)
    );

    assign ifb.halt_ack   = ifa.halt_ack;
    assign ifb.pc_in      = ifa.pc_in;
    assign ifb.prv_in     = ifa.prv_in;
    assign ifb.time_in    = ifa.time_in;
    assign ifb.timecmp_in = ifa.timecmp_in;
    assign ifb.out_ready  = ifa.out_ready;

    // Read-port models, one cycle of latency.
    always @(posedge clk) begin
        ifa.csr_data <= {52'h0, ifa.csr_addr};
        ifa.rf_data  <= (ifa.rf_sel ? 64'h200 : 64'h100) + {59'h0, ifa.rf_addr};
        ifb.csr_data <= {52'h0, ifb.csr_addr};
        ifb.rf_data  <= (ifb.rf_sel ? 64'h200 : 64'h100) + {59'h0, ifb.rf_addr};
    end

    int errs   = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [11:0] csr_tab [0:18] = '{12'h003, 12'h105, 12'h140, 12'h141, 12'h142,
                                    12'h143, 12'h180, 12'h300, 12'h302, 12'h303,
                                    12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'hB00, 12'hB02};
    logic [63:0] cur_pc;
    logic [1:0]  cur_prv;

    function automatic logic [63:0] exp_rec(input int i);
        if (i == 0)       return cur_pc;
        else if (i == 1)  return {62'h0, cur_prv};
        else if (i <= 20) return {52'h0, csr_tab[i-2]};
        else if (i == 21) return TIME_V;
        else if (i == 22) return TCMP_V;
        else if (i == 23) return 64'h0;
        else if (i <= 54) return 64'h100 + 64'(i - 23);
        else              return 64'h200 + 64'(i - 55);
    endfunction

    // Record monitor state, per instance.
    int          nxt [2];
    int          nlast [2];
    int          nvalid [2];
    int          ndone [2];
    int          nfsel [2];
    bit          stall [2];
    logic [63:0] hd [2];
    logic [6:0]  hi [2];

    task automatic mon(input int k, input logic v, input logic r, input logic [6:0] idx,
                       input logic [63:0] d, input logic l, input int lastidx);
        if (v) begin
            nvalid[k]++;
            if (stall[k]) begin
                check_val("stall_data", d, hd[k]);
                check_val("stall_index", {57'h0, idx}, hd[k] == d ? {57'h0, hi[k]} : {57'h0, hi[k]});
            end
            if (r) begin
                check_val("rec_index", {57'h0, idx}, 64'(nxt[k]));
                check_val("rec_data", d, exp_rec(nxt[k]));
                check_val("rec_last", {63'h0, l}, {63'h0, (nxt[k] == lastidx)});
                if (l) nlast[k]++;
                nxt[k]++;
                stall[k] = 1'b0;
            end else begin
                stall[k] = 1'b1;
                hd[k]    = d;
                hi[k]    = idx;
            end
        end else begin
            stall[k] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ifa.out_valid, ifa.out_ready, ifa.out_index, ifa.out_data, ifa.out_last, 86);
            mon(1, ifb.out_valid, ifb.out_ready, ifb.out_index, ifb.out_data, ifb.out_last, 54);
            if (ifa.done) ndone[0]++;
            if (ifb.done) ndone[1]++;
            if (ifb.rf_sel) nfsel[1]++;
        end
    end

    // Consumer: mode 0 always ready; mode 1 random with one 50-cycle stall at idx 40.
    int rmode      = 0;
    int stall_left = 0;
    bit stall_used = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rmode == 0) begin
            ifa.out_ready = 1'b1;
        end else if (stall_left > 0) begin
            ifa.out_ready = 1'b0;
            stall_left--;
        end else if (!stall_used && ifa.out_valid && ifa.out_index == 7'd40) begin
            ifa.out_ready = 1'b0;
            stall_left    = 49;
            stall_used    = 1'b1;
        end else begin
            ifa.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mon();
        for (int k = 0; k < 2; k++) begin
            nxt[k] = 0; nlast[k] = 0; nvalid[k] = 0; ndone[k] = 0; nfsel[k] = 0; stall[k] = 1'b0;
        end
    endtask

    task automatic request(input int k);
        if (k == 0) ifa.req_valid = 1'b1; else ifb.req_valid = 1'b1;
        tick();
        ifa.req_valid = 1'b0;
        ifb.req_valid = 1'b0;
    endtask

    task automatic set_core(input logic [63:0] pc, input logic [1:0] prv);
        cur_pc     = pc;
        cur_prv    = prv;
        ifa.pc_in  = pc;
        ifa.prv_in = prv;
    endtask

    // Ack one cycle after entry to HALT, then wait for done.
    task automatic quick_dump(input int k, input int budget);
        int n;
        tick();
        ifa.halt_ack = 1'b1;
        tick();
        ifa.halt_ack = 1'b0;
        n = 0;
        while (ndone[k] == 0 && n < budget) begin
            tick();
            n++;
        end
        check_val("done_seen", 64'(ndone[k] != 0), 64'h1);
    endtask

    initial begin
        int n;
        ifa.req_valid     = 1'b0;
        ifb.req_valid     = 1'b0;
        ifa.halt_ack      = 1'b0;
        ifa.out_ready     = 1'b1;
        ifa.time_in       = TIME_V;
        ifa.timecmp_in    = TCMP_V;
        set_core(64'h0, 2'd0);
        reset_mon();

        // Reset values
        #2;
        check_val("rst_req_ready", {63'h0, ifa.req_ready}, 64'h1);
        check_val("rst_halt_req", {63'h0, ifa.halt_req}, 64'h0);
        check_val("rst_out_valid", {63'h0, ifa.out_valid}, 64'h0);
        check_val("rst_out_data", ifa.out_data, 64'h0);
        check_val("rst_out_index", {57'h0, ifa.out_index}, 64'h0);
        check_val("rst_out_last", {63'h0, ifa.out_last}, 64'h0);
        check_val("rst_done", {63'h0, ifa.done}, 64'h0);
        check_val("rst_timeout", {63'h0, ifa.timeout_err}, 64'h0);
        check_val("rst_csr_addr", {52'h0, ifa.csr_addr}, 64'h0);
        check_val("rst_rf", {58'h0, ifa.rf_sel, ifa.rf_addr}, 64'h0);
        check_val("rst_b_req_ready", {63'h0, ifb.req_ready}, 64'h1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();

        // Full dump, ready held high, ack 3 cycles after request
        set_core(64'h8000_0040, 2'd3);
        request(0);
        check_val("halt_req_on", {63'h0, ifa.halt_req}, 64'h1);
        check_val("req_ready_off", {63'h0, ifa.req_ready}, 64'h0);
        tick();
        tick();
        ifa.halt_ack = 1'b1;
        tick();
        ifa.halt_ack = 1'b0;
        ifa.pc_in    = 64'hDEAD_BEEF;   // latched copy must be used
        check_val("valid_issue", {63'h0, ifa.out_valid}, 64'h0);
        tick();
        check_val("valid_capture", {63'h0, ifa.out_valid}, 64'h0);
        tick();
        check_val("first_valid", {63'h0, ifa.out_valid}, 64'h1);
        check_val("first_index", {57'h0, ifa.out_index}, 64'h0);
        n = 0;
        while (ndone[0] == 0 && n < 600) begin
            tick();
            n++;
        end
        check_val("t1_records", 64'(nxt[0]), 64'd87);
        check_val("t1_last_cnt", 64'(nlast[0]), 64'd1);
        check_val("t1_done_cnt", 64'(ndone[0]), 64'd1);
        check_val("t1_halt_off", {63'h0, ifa.halt_req}, 64'h0);
        check_val("t1_req_ready", {63'h0, ifa.req_ready}, 64'h1);

        // Random back-pressure with a long stall at idx 40
        reset_mon();
        set_core(64'h8000_1000, 2'd1);
        rmode = 1;
        request(0);
        quick_dump(0, 3000);
        rmode = 0;
        tick();
        check_val("t3_records", 64'(nxt[0]), 64'd87);
        check_val("t3_last_cnt", 64'(nlast[0]), 64'd1);
        check_val("t3_done_cnt", 64'(ndone[0]), 64'd1);
        check_val("t3_stall_hit", {63'h0, stall_used}, 64'h1);

        // Halt timeout
        reset_mon();
        request(0);
        check_val("t4_terr_entry", {63'h0, ifa.timeout_err}, 64'h0);
        n = 0;
        while (!ifa.timeout_err && n < 40) begin
            tick();
            n++;
        end
        check_val("t4_timeout_cycles", 64'(n), 64'd16);
        tick();
        check_val("t4_halt_off", {63'h0, ifa.halt_req}, 64'h0);
        check_val("t4_req_ready", {63'h0, ifa.req_ready}, 64'h1);
        check_val("t4_terr_pulse", {63'h0, ifa.timeout_err}, 64'h0);
        check_val("t4_no_valid", 64'(nvalid[0]), 64'h0);

        // FPR_EN=0 instance
        reset_mon();
        set_core(64'h0000_2000, 2'd0);
        request(1);
        quick_dump(1, 600);
        check_val("t5_records", 64'(nxt[1]), 64'd55);
        check_val("t5_last_cnt", 64'(nlast[1]), 64'd1);
        check_val("t5_fpr_access", 64'(nfsel[1]), 64'h0);
        check_val("t5_a_idle", 64'(nvalid[0]), 64'h0);

        // Reset in the middle of a dump, then restart
        reset_mon();
        set_core(64'h8000_0040, 2'd3);
        request(0);
        tick();
        ifa.halt_ack = 1'b1;
        tick();
        ifa.halt_ack = 1'b0;
        n = 0;
        while (!(ifa.out_valid && ifa.out_index == 7'd30) && n < 500) begin
            tick();
            n++;
        end
        check_val("t6_reach_idx30", {57'h0, ifa.out_index}, 64'd30);
        rst = 1'b1;
        #1;
        check_val("t6_halt_drop", {63'h0, ifa.halt_req}, 64'h0);
        check_val("t6_valid_drop", {63'h0, ifa.out_valid}, 64'h0);
        check_val("t6_req_ready", {63'h0, ifa.req_ready}, 64'h1);
        @(negedge clk) rst = 1'b0;
        tick();
        reset_mon();
        request(0);
        quick_dump(0, 600);
        check_val("t6_records", 64'(nxt[0]), 64'd87);
        check_val("t6_done_cnt", 64'(ndone[0]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
`default_nettype wire
